// File: rtl/multi_chain_driver.sv
// multi_chain_driver: streams the framebuffer to c_chains parallel serial LED
// chains sharing one serial clock and one latch line. A free-running frame
// timer starts each frame; every channel is shifted MSB-first from the top
// address down, then a latch pulse is issued.
// Optional build macro DRIVER_BLANK_EN adds i_blank (sampled at the frame tick)
// which forces the whole frame to shift zeros while addressing continues.
module multi_chain_driver #(
    parameter int unsigned c_ledboards    = 30,
    parameter int unsigned c_chains       = 2,
    parameter int unsigned c_bpc          = 12,
    parameter int unsigned c_clk_div      = 2,
    parameter int unsigned c_frame_period = 50000
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic [c_chains*c_bpc-1:0]         i_data,
`ifdef DRIVER_BLANK_EN
    input  logic                              i_blank,
`endif
    output logic [$clog2(c_ledboards*32)-1:0] o_addr,
    output logic                              o_clk,
    output logic [c_chains-1:0]               o_dai,
    output logic                              o_lat,
    output logic                              o_busy,
    output logic                              o_frame_start,
    output logic                              o_overrun
);

    localparam int unsigned c_nch = c_ledboards * 32;
    localparam int unsigned AW    = $clog2(c_nch);
    localparam int unsigned BW    = $clog2(c_bpc + 1);
    localparam int unsigned DW    = $clog2(c_clk_div + 1);
    localparam int unsigned TW    = $clog2(c_frame_period);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_SHIFT,
        S_LATCH
    } state_t;

    state_t                             r_state;
    logic [TW-1:0]                      r_timer;
    logic [AW-1:0]                      r_index;
    logic [DW-1:0]                      r_div;
    logic                               r_phase;
    logic [BW-1:0]                      r_bit;
    logic [c_chains-1:0][c_bpc-1:0]     r_shift;
    logic [c_chains-1:0][c_bpc-1:0]     w_load;
    logic                               w_tick;
    logic                               w_div_end;

`ifdef DRIVER_BLANK_EN
    logic                               r_blank;
    assign w_load = r_blank ? '0 : i_data;
`else
    assign w_load = i_data;
`endif

    assign w_tick    = (r_timer == TW'(c_frame_period - 1));
    assign w_div_end = (r_div == DW'(c_clk_div - 1));

    // Serial data is the MSB of each shift register; the register drains to
    // zero after c_bpc shifts, so o_dai is 0 outside an active bit.
    always_comb begin
        o_dai = '0;
        for (int k = 0; k < int'(c_chains); k++) begin
            o_dai[k] = r_shift[k][c_bpc-1];
        end
    end

    // Free-running frame timer, wraps at c_frame_period-1.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_timer <= '0;
        end else if (w_tick) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + TW'(1);
        end
    end

    // Frame sequencer: fetch/load/shift per channel, then latch.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_index       <= AW'(c_nch - 1);
            r_div         <= '0;
            r_phase       <= 1'b0;
            r_bit         <= '0;
            r_shift       <= '0;
            o_addr        <= '0;
            o_clk         <= 1'b0;
            o_lat         <= 1'b0;
            o_busy        <= 1'b0;
            o_frame_start <= 1'b0;
            o_overrun     <= 1'b0;
`ifdef DRIVER_BLANK_EN
            r_blank       <= 1'b0;
`endif
        end else begin
            o_frame_start <= 1'b0;
            if (w_tick && (r_state != S_IDLE)) begin
                o_overrun <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_tick) begin
                        r_state       <= S_FETCH;
                        o_frame_start <= 1'b1;
                        o_busy        <= 1'b1;
                        r_index       <= AW'(c_nch - 1);
                        o_addr        <= AW'(c_nch - 1);
`ifdef DRIVER_BLANK_EN
                        r_blank       <= i_blank;
`endif
                    end
                end
                S_FETCH: begin
                    o_clk   <= 1'b0;
                    r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_shift <= w_load;
                    r_div   <= '0;
                    r_phase <= 1'b0;
                    r_bit   <= '0;
                    r_state <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (!w_div_end) begin
                        r_div <= r_div + DW'(1);
                    end else begin
                        r_div <= '0;
                        if (!r_phase) begin
                            r_phase <= 1'b1;
                            o_clk   <= 1'b1;
                        end else begin
                            r_phase <= 1'b0;
                            o_clk   <= 1'b0;
                            for (int k = 0; k < int'(c_chains); k++) begin
                                r_shift[k] <= {r_shift[k][c_bpc-2:0], 1'b0};
                            end
                            if (r_bit == BW'(c_bpc - 1)) begin
                                if (r_index == '0) begin
                                    r_state <= S_LATCH;
                                    o_lat   <= 1'b1;
                                end else begin
                                    r_index <= r_index - AW'(1);
                                    o_addr  <= r_index - AW'(1);
                                    r_state <= S_FETCH;
                                end
                            end else begin
                                r_bit <= r_bit + BW'(1);
                            end
                        end
                    end
                end
                S_LATCH: begin
                    // Two divider periods of latch, reusing the phase bit.
                    if (!w_div_end) begin
                        r_div <= r_div + DW'(1);
                    end else begin
                        r_div <= '0;
                        if (!r_phase) begin
                            r_phase <= 1'b1;
                        end else begin
                            r_phase <= 1'b0;
                            o_lat   <= 1'b0;
                            o_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi_chain_driver.sv
// Testbench for multi_chain_driver: two instances (frame period 400 and 300)
// checked per cycle against a frame-level reference model and a scoreboard.
module tb_multi_chain_driver;

    localparam int NB     = 1;
    localparam int NC     = 2;
    localparam int B      = 4;
    localparam int D      = 1;
    localparam int N      = NB * 32;
    localparam int PER_CH = 2 + 2 * D * B;
    localparam int L      = N * PER_CH + 2 * D;

    typedef struct packed {
        logic       clk;
        logic       lat;
        logic       dai_care;
        logic [1:0] dai;
        logic       addr_care;
        logic [4:0] addr;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] data      [2];
    logic [4:0] addr      [2];
    logic       sclk      [2];
    logic [1:0] dai       [2];
    logic       lat       [2];
    logic       busy      [2];
    logic       fs        [2];
    logic       ovr       [2];
`ifdef DRIVER_BLANK_EN
    logic       blank;
`endif

    int   n_checks;
    int   n_errors;
    bit   done;
    bit   exp_fs   [2];
    bit   exp_busy [2];
    bit   exp_ovr  [2];
    exp_t q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        multi_chain_driver #(
            .c_ledboards   (NB),
            .c_chains      (NC),
            .c_bpc         (B),
            .c_clk_div     (D),
            .c_frame_period(g == 0 ? 400 : 300)
        ) u_dut (
            .i_clk        (clk),
            .i_rst_n      (rst_n),
            .i_data       (data[g]),
`ifdef DRIVER_BLANK_EN
            .i_blank      (blank),
`endif
            .o_addr       (addr[g]),
            .o_clk        (sclk[g]),
            .o_dai        (dai[g]),
            .o_lat        (lat[g]),
            .o_busy       (busy[g]),
            .o_frame_start(fs[g]),
            .o_overrun    (ovr[g])
        );
    end

    // Framebuffer model: {chain1, chain0} = {~addr[3:0], addr[3:0]}, 1-cycle latency.
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            data[g] <= {~addr[g][3:0], addr[g][3:0]};
        end
    end

    function automatic int period(input int g);
        return (g == 0) ? 400 : 300;
    endfunction

    // Expected pins at frame offset t (t=0 is the first fetch cycle).
    function automatic exp_t frame_rec(input int t, input bit blk);
        exp_t e;
        int c, r, s, a, bp, b0;
        e = '0;
        if (t >= N * PER_CH) begin
            e.lat      = 1'b1;
            e.dai_care = 1'b1;
        end else begin
            c = t / PER_CH;
            r = t % PER_CH;
            a = N - 1 - c;
            if (r == 0) begin
                e.addr_care = 1'b1;
                e.addr      = 5'(a);
            end
            if (r >= 2) begin
                s          = r - 2;
                e.clk      = ((s % (2 * D)) >= D);
                bp         = B - 1 - s / (2 * D);
                b0         = (a >> bp) & 1;
                e.dai_care = 1'b1;
                e.dai      = blk ? 2'b00 : {1'(1 - b0), 1'(b0)};
            end
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: timer mod period, frame of L cycles, overrun on busy tick.
    task automatic model_loop();
        int tmr  [2];
        int left [2];
        bit blk;
        tmr  = '{0, 0};
        left = '{0, 0};
        while (!done) begin
            @(posedge clk);
            if (!rst_n) begin
                tmr  = '{0, 0};
                left = '{0, 0};
                for (int g = 0; g < 2; g++) begin
                    exp_fs[g]   = 1'b0;
                    exp_busy[g] = 1'b0;
                    exp_ovr[g]  = 1'b0;
                end
                q.delete();
            end else begin
`ifdef DRIVER_BLANK_EN
                blk = blank;
`else
                blk = 1'b0;
`endif
                for (int g = 0; g < 2; g++) begin
                    exp_fs[g] = 1'b0;
                    if ((tmr[g] == period(g) - 1) && (left[g] == 0)) begin
                        left[g]   = L;
                        exp_fs[g] = 1'b1;
                        if (g == 0) begin
                            for (int t = 0; t < L; t++) q.push_back(frame_rec(t, blk));
                        end
                    end else begin
                        if (tmr[g] == period(g) - 1) exp_ovr[g] = 1'b1;
                        if (left[g] > 0) left[g]--;
                    end
                    exp_busy[g] = (left[g] > 0);
                    tmr[g]      = (tmr[g] + 1) % period(g);
                end
            end
        end
    endtask

    // Monitor: per-cycle status compare; pops the scoreboard while busy.
    task automatic monitor_loop();
        exp_t e;
        int   rises;
        logic prev_clk;
        logic prev_busy;
        rises     = 0;
        prev_clk  = 1'b0;
        prev_busy = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (rst_n) begin
                for (int g = 0; g < 2; g++) begin
                    check($sformatf("frame_start[%0d]", g), 32'(fs[g]), 32'(exp_fs[g]));
                    check($sformatf("busy[%0d]", g), 32'(busy[g]), 32'(exp_busy[g]));
                    check($sformatf("overrun[%0d]", g), 32'(ovr[g]), 32'(exp_ovr[g]));
                end
                if (busy[0]) begin
                    if (sclk[0] && !prev_clk) rises++;
                    if (q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL scoreboard: busy with no expected cycle at %0t", $time);
                    end else begin
                        e = q.pop_front();
                        check("o_clk", 32'(sclk[0]), 32'(e.clk));
                        check("o_lat", 32'(lat[0]), 32'(e.lat));
                        if (e.dai_care) check("o_dai", 32'(dai[0]), 32'(e.dai));
                        if (e.addr_care) check("o_addr", 32'(addr[0]), 32'(e.addr));
                    end
                end else begin
                    check("idle_clk", 32'(sclk[0]), 32'(0));
                    check("idle_lat", 32'(lat[0]), 32'(0));
                    if (prev_busy) begin
                        check("rising_edges", 32'(rises), 32'(N * B));
                        check("queue_drained", 32'(q.size()), 32'(0));
                    end
                    rises = 0;
                end
                prev_clk  = sclk[0];
                prev_busy = busy[0];
            end else begin
                rises     = 0;
                prev_clk  = 1'b0;
                prev_busy = 1'b0;
            end
        end
    endtask

    // Counts clock edges until o_frame_start is seen; -1 on timeout.
    task automatic wait_fs(input int g, input int max, output int n);
        n = -1;
        for (int k = 1; k <= max; k++) begin
            @(posedge clk);
            #1;
            if (fs[g]) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic stim();
        int n;
        rst_n = 1'b0;
`ifdef DRIVER_BLANK_EN
        blank = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            check("rst_addr", 32'(addr[g]), 32'(0));
            check("rst_clk", 32'(sclk[g]), 32'(0));
            check("rst_dai", 32'(dai[g]), 32'(0));
            check("rst_lat", 32'(lat[g]), 32'(0));
            check("rst_busy", 32'(busy[g]), 32'(0));
            check("rst_fs", 32'(fs[g]), 32'(0));
            check("rst_ovr", 32'(ovr[g]), 32'(0));
        end
        @(negedge clk);
        rst_n = 1'b1;

        wait_fs(0, 450, n);
        check("first_start", 32'(n), 32'(400));
        wait_fs(0, 450, n);
        check("second_start", 32'(n), 32'(400));

`ifdef DRIVER_BLANK_EN
        blank = 1'b1;
        wait_fs(0, 450, n);
        check("blank_start", 32'(n), 32'(400));
        repeat (100) @(posedge clk);
        #1;
        blank = 1'b0;
        wait_fs(0, 450, n);
        check("after_blank_start", 32'(n), 32'(400));
`endif

        // Reset in the middle of the channel at address 10 (frame offset 215).
        repeat (215) @(posedge clk);
        #1;
        check("pre_reset_clk", 32'(sclk[0]), 32'(1));
        check("pre_reset_ovr1", 32'(ovr[1]), 32'(1));
        check("pre_reset_ovr0", 32'(ovr[0]), 32'(0));
        #1;
        rst_n = 1'b0;
        #1;
        check("async_clk", 32'(sclk[0]), 32'(0));
        check("async_dai", 32'(dai[0]), 32'(0));
        check("async_lat", 32'(lat[0]), 32'(0));
        check("async_busy", 32'(busy[0]), 32'(0));
        check("async_ovr1", 32'(ovr[1]), 32'(0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_fs(0, 450, n);
        check("restart_start", 32'(n), 32'(400));
        check("restart_addr", 32'(addr[0]), 32'(31));

        n = -1;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk);
            #1;
            if (!busy[0]) begin
                n = k;
                break;
            end
        end
        check("frame_end_seen", 32'(n >= 0), 32'(1));
        repeat (4) @(posedge clk);
        done = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        done     = 1'b0;
        for (int g = 0; g < 2; g++) begin
            exp_fs[g]   = 1'b0;
            exp_busy[g] = 1'b0;
            exp_ovr[g]  = 1'b0;
        end
        fork
            stim();
            model_loop();
            monitor_loop();
        join
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
